// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the execute-stage multiply/divide unit.
// Contents: op and FSM state enums, divide-by-zero quotient constant, op helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } muldiv_state_t;

    // Quotient returned on divide by zero; sliced to the unit width.
    localparam logic [63:0] DIV_BY_ZERO_LO = '1;

    function automatic logic is_signed_op(input muldiv_op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input muldiv_op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports: rem_i partial remainder, bit_i next dividend bit, divisor_i;
//        rem_o next partial remainder, q_o quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_i, bit_i};
    assign q_o     = (shifted >= {1'b0, divisor_i});

    // When the divisor fits, the true difference is below the divisor,
    // so the low WIDTH bits of the modular subtraction are exact.
    assign rem_o = q_o ? (shifted[WIDTH-1:0] - divisor_i)
                       : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports: clk, reset_n (async active-low), start/op/a/b issue, flush abort,
//        mthi/mtlo moves from a; busy stall, done pulse, hi/lo outputs.
// Option: define MULDIV_FAST_MUL_EN for a single-cycle multiply path.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    muldiv_op_t       op_in;
    logic             in_signed;
    logic             neg_a_in;
    logic             neg_b_in;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign op_in     = muldiv_op_t'(op);
    assign in_signed = is_signed_op(op_in);
    assign neg_a_in  = in_signed & a[WIDTH-1];
    assign neg_b_in  = in_signed & b[WIDTH-1];
    assign abs_a     = neg_a_in ? -a : a;
    assign abs_b     = neg_b_in ? -b : b;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0] mul_sum;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: acc holds {partial remainder, dividend bits / quotient bits}.
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
        .bit_i     (acc_q[WIDTH-1]),
        .divisor_i (opnd_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Sign correction applied in FIX.
    logic               res_neg;
    logic               div_zero;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign res_neg  = neg_a_q ^ neg_b_q;
    assign div_zero = (opnd_q == '0);
    assign prod_fix = res_neg ? -acc_q : acc_q;
    assign quo_raw  = acc_q[WIDTH-1:0];
    assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];
    assign quo_fix  = div_zero ? DIV_BY_ZERO_LO[WIDTH-1:0]
                               : (res_neg ? -quo_raw : quo_raw);
    // With a zero divisor every step shifts the dividend through the
    // remainder unchanged, so the remainder path already yields a.
    assign rem_fix  = neg_a_q ? -rem_raw : rem_raw;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d    = op_in;
                    neg_a_d = neg_a_in;
                    neg_b_d = neg_b_in;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    if (is_div_op(op_in)) begin
                        opnd_d  = abs_b;
                        acc_d   = {{WIDTH{1'b0}}, abs_a};
                        state_d = CALC;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        opnd_d  = abs_a;
                        acc_d   = {{WIDTH{1'b0}}, abs_a}
                                * {{WIDTH{1'b0}}, abs_b};
                        state_d = FIX;
`else
                        opnd_d  = abs_a;
                        acc_d   = {{WIDTH{1'b0}}, abs_b};
                        state_d = CALC;
`endif
                    end
                end else if (!start) begin
                    if (mthi) hi_d = a;
                    if (mtlo) lo_d = a;
                end
            end
            CALC: begin
                if (is_div_op(op_q)) begin
                    acc_d = {step_rem, acc_q[WIDTH-2:0], step_q};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_op(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort leaves HI/LO untouched and suppresses the done pulse.
        if (flush && state_q != IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit beside the single-cycle ALU in the execute stage.
- Executes MULT, MULTU, DIV and DIVU over many cycles and holds results in the architectural HI/LO registers.
- Execute stage issues an operation with a start pulse, stalls on busy, and reads HI/LO (MFHI/MFLO) or writes them (MTHI/MTLO).

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  issue request, sampled only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand/dividend)
- b  input  WIDTH  rt operand (multiplier/divisor)
- flush  input  1  abort in-flight operation (exception/branch squash)
- mthi, mtlo  input  1 each  write a into HI / LO
- busy  output  1  operation in flight; execute stage must stall
- done  output  1  one-cycle pulse when HI/LO receive a new result
- hi, lo  output  WIDTH each  architectural HI/LO registers

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n).
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, all internal counters and accumulators 0.
- FSM states: IDLE, CALC, FIX.
  - IDLE: if start, latch |a|, |b| and sign flags (signed ops), load counter=WIDTH-1, go CALC.
  - CALC: one radix-2 step per cycle (shift-add multiply; restoring divide). At counter==0 go FIX, else decrement.
  - FIX: apply sign correction, write HI/LO, pulse done, return to IDLE.
- Latency: start high at edge k gives busy=1 for cycles k+1 .. k+WIDTH+1. HI/LO update and done=1 occur in the cycle after edge k+WIDTH+1 (34 edges for WIDTH=32). busy=0 in the done cycle.
- Multiply results:
  - {hi,lo} = full 2*WIDTH-bit product.
  - Signed product is negated when the operand signs differ.
- Divide results:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero: lo = all ones, hi = a (dividend unmodified). Still takes full latency, no exception.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0. No overflow flag, matching the ALU's "no trap for mul/div" rule.
- start while busy: ignored. Issuer must hold the stall; a second op is never queued.
- flush: synchronous; any state returns to IDLE next edge. HI/LO unchanged, done not pulsed. flush in IDLE with start: start is dropped.
- mthi/mtlo:
  - Honoured only in IDLE with start=0; takes effect next edge.
  - In IDLE with start=1: start wins, the move is dropped.
  - While busy: ignored.
  - mthi and mtlo together: both written with a.
- hi/lo change only on FIX completion, mthi/mtlo, or reset. They are stable for MFHI/MFLO at all other times.
- reset_n low mid-operation: immediate return to the reset values above.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU skip CALC. IDLE -> FIX uses a single combinational WIDTH x WIDTH product registered at the start edge. done arrives 2 edges after start; busy=1 for one cycle. Division unchanged.
- Undefined: all operations use the iterative path with WIDTH+2 latency.

Decomposition:
- Package mips_pkg:
  - muldiv_op_t enum (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - muldiv_state_t enum (IDLE, CALC, FIX)
  - localparam DIV_BY_ZERO_LO = '1
- Sub-module div_step: combinational single restoring-division step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once and reused each CALC cycle.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> after 34 edges: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; second start issued mid-operation is ignored, with one done pulse only.
- mthi a=0x12345678 in IDLE -> hi=0x12345678 next edge. Start MULTU, assert flush on cycle 10 -> IDLE next edge, hi still 0x12345678, done never pulses.
- Assert reset_n=0 mid-CALC between clock edges -> busy, done, hi and lo go to 0 immediately without a clock edge.
